// File: rtl/seg7_capture.sv
// rtl/seg7_capture.sv - seven-segment bus snooper recovering a multi-digit hex frame (option: SEG7_CAP_DP_EN)
module seg7_capture #(
    parameter int DIGITS     = 4,
    parameter int STABLE_CNT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     dig_sel,
`ifdef SEG7_CAP_DP_EN
    input  logic                  seg_dp,
    output logic [DIGITS-1:0]     dp_out,
`endif
    output logic [4*DIGITS-1:0]   value_out,
    output logic                  valid_out,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int         IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [7:0] CNT_MAX = 8'(STABLE_CNT);

`ifdef SEG7_CAP_DP_EN
    localparam int SW = 8 + DIGITS;
`else
    localparam int SW = 7 + DIGITS;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DONE
    } state_t;

    logic [SW-1:0]       in_word;
    logic [SW-1:0]       s_word;
    logic [SW-1:0]       p_word;
    logic [6:0]          s_seg;
    logic [DIGITS-1:0]   s_sel;
    logic [7:0]          cnt;
    logic                sel_onehot;
    logic                same;
    logic                cap;
    logic [IW-1:0]       idx;
    logic [3:0]          cap_nib;
    logic                cap_ill;

    state_t              state, state_n;
    logic [DIGITS-1:0]   mask, mask_n;
    logic [DIGITS-1:0]   err, err_n;
    logic [4*DIGITS-1:0] nib_q, nib_n;
    logic                load;

`ifdef SEG7_CAP_DP_EN
    assign in_word = {seg_dp, dig_sel, seg_in};
`else
    assign in_word = {dig_sel, seg_in};
`endif

    assign s_seg      = s_word[6:0];
    assign s_sel      = s_word[7 +: DIGITS];
    assign sel_onehot = $onehot(s_sel);
    assign same       = (s_word == p_word);

    // A digit is taken exactly once per dwell: on the match that lifts the count to its ceiling.
    assign cap  = same && sel_onehot && (cnt == CNT_MAX - 8'd1);
    assign busy = (state == ST_COLLECT);

    // Returns {illegal, nibble}; unknown patterns decode to nibble 0.
    function automatic logic [4:0] seg_decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h3F:   r = 5'h00;
            7'h06:   r = 5'h01;
            7'h5B:   r = 5'h02;
            7'h4F:   r = 5'h03;
            7'h66:   r = 5'h04;
            7'h6D:   r = 5'h05;
            7'h7D:   r = 5'h06;
            7'h07:   r = 5'h07;
            7'h7F:   r = 5'h08;
            7'h67:   r = 5'h09;
            7'h77:   r = 5'h0A;
            7'h7C:   r = 5'h0B;
            7'h39:   r = 5'h0C;
            7'h5E:   r = 5'h0D;
            7'h79:   r = 5'h0E;
            7'h71:   r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    assign {cap_ill, cap_nib} = seg_decode(s_seg);

    // Convert the one-hot select of the current sample into a digit index.
    always_comb begin
        idx = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (s_sel[k]) idx = IW'(k);
        end
    end

    // Input stage: current sample S and the sample before it P.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_word <= '0;
            p_word <= '0;
        end else begin
            s_word <= in_word;
            p_word <= s_word;
        end
    end

    // Stability counter: counts matching one-hot samples, saturates, clears on anything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (same && sel_onehot) begin
            if (cnt != CNT_MAX) cnt <= cnt + 8'd1;
        end else begin
            cnt <= '0;
        end
    end

    // Frame FSM state register together with the capture mask, error bits and nibble buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            mask  <= '0;
            err   <= '0;
            nib_q <= '0;
        end else begin
            state <= state_n;
            mask  <= mask_n;
            err   <= err_n;
            nib_q <= nib_n;
        end
    end

    // Next-state logic: fold each capture into the buffer, finish when every digit has been seen.
    always_comb begin
        state_n = state;
        mask_n  = mask;
        err_n   = err;
        nib_n   = nib_q;
        load    = 1'b0;
        case (state)
            ST_IDLE, ST_COLLECT: begin
                if (cap) begin
                    mask_n[idx]                = 1'b1;
                    err_n[idx]                 = cap_ill;
                    nib_n[{idx, 2'b00} +: 4]   = cap_nib;
                    if (mask_n == '1) begin
                        state_n = ST_DONE;
                        load    = 1'b1;
                    end else begin
                        state_n = ST_COLLECT;
                    end
                end
            end
            ST_DONE: begin
                mask_n  = '0;
                err_n   = '0;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Publish the completed frame; valid_out is high for the DONE cycle only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_out <= '0;
            frame_err <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= load;
            if (load) begin
                value_out <= nib_n;
                frame_err <= |err_n;
            end
        end
    end

`ifdef SEG7_CAP_DP_EN
    logic [DIGITS-1:0] dp_q, dp_n;

    // Decimal point of each captured digit rides along with its nibble.
    always_comb begin
        dp_n = dp_q;
        if (cap && state != ST_DONE) dp_n[idx] = s_word[SW-1];
    end

    // Decimal point buffer and its published copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_q   <= '0;
            dp_out <= '0;
        end else begin
            dp_q <= dp_n;
            if (load) dp_out <= dp_n;
        end
    end
`else
`endif

endmodule

// File: tb/tb_seg7_capture.sv
// tb/tb_seg7_capture.sv - directed and randomized bench for seg7_capture against a frame-level model
module tb_seg7_capture;

    localparam int DIGITS = 4;
    localparam int SC     = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [3:0]  dig_sel;
    logic [15:0] value_out;
    logic        valid_out;
    logic        frame_err;
    logic        busy;
`ifdef SEG7_CAP_DP_EN
    logic        seg_dp;
    logic [3:0]  dp_out;
    logic        next_dp;
    logic [3:0]  m_dpb;
    logic [3:0]  m_dp_out;
`endif

    seg7_capture #(.DIGITS(DIGITS), .STABLE_CNT(SC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .dig_sel   (dig_sel),
`ifdef SEG7_CAP_DP_EN
        .seg_dp    (seg_dp),
        .dp_out    (dp_out),
`endif
        .value_out (value_out),
        .valid_out (valid_out),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int bad    = 0;
    int vcount = 0;

    logic [6:0] fwd [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int          m_mask   = 0;
    int          m_frames = 0;
    logic [3:0]  m_nib [4];
    logic        m_err [4];
    logic [15:0] m_val    = '0;
    logic        m_ferr   = 1'b0;

    always @(negedge clk) begin
        if (valid_out === 1'b1) vcount++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear_frame();
        m_mask = 0;
        for (int i = 0; i < 4; i++) m_err[i] = 1'b0;
    endtask

    // Hold a select/pattern for n input cycles, then blank for two cycles, then compare.
    task automatic dwell(input logic [3:0] sel, input logic [6:0] seg, input int n);
        int  k;
        int  nib;
        bit  legal;
        seg_in  = seg;
        dig_sel = sel;
`ifdef SEG7_CAP_DP_EN
        seg_dp  = next_dp;
`endif
        repeat (n) @(posedge clk);
        #1;
        dig_sel = '0;
        seg_in  = '0;
`ifdef SEG7_CAP_DP_EN
        seg_dp  = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        if ($countones(sel) == 1 && n >= SC + 1) begin
            k = 0;
            for (int i = 0; i < 4; i++) if (sel[i]) k = i;
            nib   = 0;
            legal = 0;
            for (int i = 0; i < 16; i++) begin
                if (fwd[i] == seg) begin
                    nib   = i;
                    legal = 1;
                end
            end
            m_nib[k] = nib[3:0];
            m_err[k] = !legal;
`ifdef SEG7_CAP_DP_EN
            m_dpb[k] = next_dp;
`endif
            m_mask   = m_mask | (1 << k);
            if (m_mask == 15) begin
                m_frames++;
                m_val  = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
                m_ferr = m_err[0] | m_err[1] | m_err[2] | m_err[3];
`ifdef SEG7_CAP_DP_EN
                m_dp_out = m_dpb;
`endif
                model_clear_frame();
            end
        end
        check("valid_count", vcount, m_frames);
        check("busy", busy, (m_mask != 0));
        check("value_out", value_out, m_val);
        check("frame_err", frame_err, m_ferr);
`ifdef SEG7_CAP_DP_EN
        check("dp_out", dp_out, m_dp_out);
`endif
    endtask

    initial begin
        int pick;
        logic [3:0] rsel;
        logic [6:0] rseg;

        rst_n   = 1'b0;
        seg_in  = '0;
        dig_sel = '0;
`ifdef SEG7_CAP_DP_EN
        seg_dp   = 1'b0;
        next_dp  = 1'b0;
        m_dpb    = '0;
        m_dp_out = '0;
`endif
        for (int i = 0; i < 4; i++) begin
            m_nib[i] = '0;
            m_err[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_value", value_out, 16'h0000);
        check("rst_err", frame_err, 1'b0);
        check("rst_valid", valid_out, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        dwell(4'b0001, 7'h4F, 6);
        dwell(4'b0010, 7'h66, 6);
        dwell(4'b0100, 7'h6D, 6);
        dwell(4'b1000, 7'h7D, 6);
        check("frame1_value", value_out, 16'h6543);
        check("frame1_valids", vcount, 1);

        dwell(4'b0100, 7'h39, 6);
        dwell(4'b0001, 7'h06, 6);
        dwell(4'b1000, 7'h7C, 6);
        dwell(4'b0010, 7'h5E, 6);
        check("frame2_value", value_out, 16'hBCD1);
        check("frame2_valids", vcount, 2);

        dwell(4'b0001, 7'h3F, 6);
        dwell(4'b0010, 7'h7E, 6);
        dwell(4'b0100, 7'h3F, 6);
        dwell(4'b1000, 7'h3F, 6);
        check("frame3_value", value_out, 16'h0000);
        check("frame3_err", frame_err, 1'b1);

        dwell(4'b0001, 7'h4F, SC);
        check("short_busy", busy, 1'b0);
        dwell(4'b0011, 7'h4F, 8);
        check("multisel_busy", busy, 1'b0);
        dwell(4'b0001, 7'h4F, SC + 1);
        check("min_dwell_busy", busy, 1'b1);

        dwell(4'b0010, 7'h06, 6);
        dwell(4'b0100, 7'h5B, 6);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_value", value_out, 16'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear_frame();
        m_val  = '0;
        m_ferr = 1'b0;
`ifdef SEG7_CAP_DP_EN
        m_dp_out = '0;
`endif
        @(posedge clk);
        #1;
        dwell(4'b0001, 7'h06, 6);
        dwell(4'b0001, 7'h5B, 6);
        dwell(4'b1000, 7'h77, 6);
        dwell(4'b0010, 7'h67, 6);
        dwell(4'b0100, 7'h07, 6);
        check("overwrite_value", value_out, 16'hA792);
        check("post_rst_valids", vcount, 4);

        for (int r = 0; r < 60; r++) begin
            pick = $urandom_range(0, 9);
            rsel = (pick == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
            pick = $urandom_range(0, 9);
            rseg = (pick < 2) ? 7'($urandom) : fwd[$urandom_range(0, 15)];
`ifdef SEG7_CAP_DP_EN
            next_dp = 1'($urandom);
`endif
            dwell(rsel, rseg, $urandom_range(SC - 1, SC + 4));
        end

`ifdef SEG7_CAP_DP_EN
        model_clear_frame();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        m_val  = '0;
        m_ferr = 1'b0;
        m_dp_out = '0;
        for (int d = 0; d < 4; d++) begin
            next_dp = (d == 2);
            dwell(4'(1 << d), 7'h7F, 6);
        end
        check("dp_value", value_out, 16'h8888);
        check("dp_bits", dp_out, 4'b0100);
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
